// File: rtl/im_pkg.sv
// Shared defaults and state encoding for the image-engine BRAM host.
package im_pkg;

    localparam int IM_N      = 128;
    localparam int IM_ADDR_W = 14;
    localparam int IM_DATA_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DUMP   = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

endpackage

// File: rtl/im_bram_bank.sv
// Single-port image bank: write-first, registered read, output holds while disabled.
module im_bram_bank #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem[addr] <= din;
        end
    end

    // Read register: a write returns the new data, an idle cycle keeps the last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (ena) begin
            dout <= wea ? din : mem[addr];
        end
    end

endmodule

// File: rtl/im_bram_host.sv
// Host end of the image-engine BRAM bundle: loads two banks from a byte
// stream, lets an engine run on them, then streams bank 2 back out.
module im_bram_host
    import im_pkg::*;
#(
    parameter int N      = IM_N,
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              begin_engine,
    input  logic              engine_done,
    input  logic              eng_ena_1,
    input  logic              eng_ena_2,
    input  logic              eng_wea_1,
    input  logic              eng_wea_2,
    input  logic [ADDR_W-1:0] eng_addr_1,
    input  logic [ADDR_W-1:0] eng_addr_2,
    input  logic [DATA_W-1:0] eng_din_1,
    input  logic [DATA_W-1:0] eng_din_2,
    output logic [DATA_W-1:0] eng_dout_1,
    output logic [DATA_W-1:0] eng_dout_2
);

    localparam int DEPTH = N * N;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] load_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] acc_cnt;
    logic              rd_active;
    logic              rd_pend;
    logic [1:0]        buf_cnt;
    logic [1:0]        occ;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic [DATA_W-1:0] hold_1;
    logic [DATA_W-1:0] hold_2;

    logic              in_run;
    logic              in_dump;
    logic              s_fire;
    logic              m_fire;
    logic              rd_issue;

    logic              b1_ena, b1_wea, b2_ena, b2_wea;
    logic [ADDR_W-1:0] b1_addr, b2_addr;
    logic [DATA_W-1:0] b1_din, b2_din;
    logic [DATA_W-1:0] b1_dout, b2_dout;

    assign in_run  = (state == ST_RUN);
    assign in_dump = (state == ST_DUMP);
    assign s_ready = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign s_fire  = s_valid && s_ready;
    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf0;
    assign m_fire  = m_valid && m_ready;

    // A read is only launched when its data is guaranteed a slot in the skid buffer,
    // counting the read already in flight and any byte leaving this cycle.
    assign occ      = buf_cnt + {1'b0, rd_pend};
    assign rd_issue = in_dump && rd_active && ((occ < 2'd2) || m_fire);

    // While the engine holds the banks its dout tracks them live; otherwise it holds.
    assign eng_dout_1 = in_run ? b1_dout : hold_1;
    assign eng_dout_2 = in_run ? b2_dout : hold_2;

    // Bank port steering: engine owns both banks in RUN, the host owns them elsewhere.
    always_comb begin
        b1_ena  = 1'b0;
        b1_wea  = 1'b0;
        b1_addr = load_cnt;
        b1_din  = s_data;
        b2_ena  = 1'b0;
        b2_wea  = 1'b0;
        b2_addr = load_cnt;
        b2_din  = s_data;
        if (in_run) begin
            b1_ena  = eng_ena_1;
            b1_wea  = eng_wea_1;
            b1_addr = eng_addr_1;
            b1_din  = eng_din_1;
            b2_ena  = eng_ena_2;
            b2_wea  = eng_wea_2;
            b2_addr = eng_addr_2;
            b2_din  = eng_din_2;
        end else if (state == ST_LOAD_A) begin
            b1_ena = s_fire;
            b1_wea = s_fire;
        end else if (state == ST_LOAD_B) begin
            b2_ena = s_fire;
            b2_wea = s_fire;
        end else if (in_dump) begin
            b2_ena  = rd_issue;
            b2_addr = rd_addr;
        end
    end

    im_bram_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_1 (
        .clk  (clk),
        .rst  (rst),
        .ena  (b1_ena),
        .wea  (b1_wea),
        .addr (b1_addr),
        .din  (b1_din),
        .dout (b1_dout)
    );

    im_bram_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_2 (
        .clk  (clk),
        .rst  (rst),
        .ena  (b2_ena),
        .wea  (b2_wea),
        .addr (b2_addr),
        .din  (b2_din),
        .dout (b2_dout)
    );

    // Sequencer: load A, load B, run engine, dump bank 2, pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            begin_engine <= 1'b0;
            load_cnt     <= '0;
            acc_cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD_A;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD_A, ST_LOAD_B: begin
                    if (s_fire) begin
                        if (load_cnt == LAST_ADDR) begin
                            load_cnt <= '0;
                            if (state == ST_LOAD_A) begin
                                state <= ST_LOAD_B;
                            end else begin
                                state        <= ST_RUN;
                                begin_engine <= 1'b1;
                            end
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (engine_done) begin
                        begin_engine <= 1'b0;
                        state        <= ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    if (m_fire) begin
                        if (acc_cnt == LAST_ADDR) begin
                            acc_cnt <= '0;
                            state   <= ST_FIN;
                            done    <= 1'b1;
                        end else begin
                            acc_cnt <= acc_cnt + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Dump read side: walk bank 2 addresses and remember whether a read is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr   <= '0;
            rd_active <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
            if (in_run && engine_done) begin
                rd_active <= 1'b1;
                rd_addr   <= '0;
            end else if (rd_issue) begin
                if (rd_addr == LAST_ADDR) begin
                    rd_active <= 1'b0;
                    rd_addr   <= '0;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

    // Two-entry skid buffer; buf0 is always the head presented on m_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            case ({rd_pend, m_fire})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf0 <= b2_dout;
                    end else begin
                        buf1 <= b2_dout;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= b2_dout;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= b2_dout;
                    end
                end
                default: begin
                    buf_cnt <= buf_cnt;
                end
            endcase
        end
    end

    // Capture what the engine last saw so eng_dout stays put once it loses the banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_1 <= '0;
            hold_2 <= '0;
        end else if (in_run) begin
            hold_1 <= b1_dout;
            hold_2 <= b2_dout;
        end
    end

endmodule

// File: tb/tb_im_bram_host.sv
// Directed bench for im_bram_host with a 4x4 image.
module tb_im_bram_host;

    localparam int N      = 4;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              begin_engine;
    logic              engine_done;
    logic              eng_ena_1, eng_ena_2;
    logic              eng_wea_1, eng_wea_2;
    logic [ADDR_W-1:0] eng_addr_1, eng_addr_2;
    logic [DATA_W-1:0] eng_din_1, eng_din_2;
    logic [DATA_W-1:0] eng_dout_1, eng_dout_2;

    int checks = 0;
    int errors = 0;

    im_bram_host #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .begin_engine (begin_engine),
        .engine_done  (engine_done),
        .eng_ena_1    (eng_ena_1),
        .eng_ena_2    (eng_ena_2),
        .eng_wea_1    (eng_wea_1),
        .eng_wea_2    (eng_wea_2),
        .eng_addr_1   (eng_addr_1),
        .eng_addr_2   (eng_addr_2),
        .eng_din_1    (eng_din_1),
        .eng_din_2    (eng_din_2),
        .eng_dout_1   (eng_dout_1),
        .eng_dout_2   (eng_dout_2)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [DATA_W-1:0] v);
        int waitCycles;
        waitCycles = 0;
        s_valid = 1'b1;
        s_data  = v;
        @(negedge clk);
        while (!s_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!s_ready) checkOutput("s_ready_timeout", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Streams count bytes starting at firstVal; optionally pokes the engine
    // write ports and/or pulses start while loading.
    task automatic applyStimulus(input int firstVal, input int count, input bit poke, input bit startMid);
        for (int i = 0; i < count; i++) begin
            if (poke) begin
                eng_ena_1  = (i < 30);
                eng_wea_1  = (i < 30);
                eng_ena_2  = (i < 30);
                eng_wea_2  = (i < 30);
                eng_addr_1 = 4'd2;
                eng_addr_2 = 4'd2;
                eng_din_1  = 8'hEE;
                eng_din_2  = 8'hEE;
            end
            start = startMid && (i == 3);
            sendByte(DATA_W'(firstVal + i));
            start = 1'b0;
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_s_ready"}, s_ready, 0);
        checkOutput({tag, "_m_valid"}, m_valid, 0);
        checkOutput({tag, "_m_data"}, m_data, 0);
        checkOutput({tag, "_begin_engine"}, begin_engine, 0);
        checkOutput({tag, "_eng_dout_1"}, eng_dout_1, 0);
        checkOutput({tag, "_eng_dout_2"}, eng_dout_2, 0);
    endtask

    initial begin
        int a;
        int b;
        int idx;
        int c;
        bit stall;

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        engine_done = 1'b0;
        eng_ena_1 = 1'b0; eng_ena_2 = 1'b0; eng_wea_1 = 1'b0; eng_wea_2 = 1'b0;
        eng_addr_1 = '0; eng_addr_2 = '0; eng_din_1 = '0; eng_din_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkIdleZero("reset");

        // Reset in the middle of LOAD_B drops everything back to idle
        @(posedge clk);
        #1;
        pulseStart();
        checkOutput("busy_after_start", busy, 1);
        applyStimulus(100, 21, 0, 0);
        checkOutput("busy_loadb", busy, 1);
        checkOutput("s_ready_loadb", s_ready, 1);
        rst = 1'b1;
        #2;
        checkIdleZero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_s_ready", s_ready, 0);

        // Run 1: A = 0..15, B = 16..31, engine writes the average into bank 2
        @(posedge clk);
        #1;
        pulseStart();
        applyStimulus(0, 32, 0, 0);
        checkOutput("run_s_ready", s_ready, 0);
        checkOutput("run_begin_engine", begin_engine, 1);
        checkOutput("run_busy", busy, 1);

        for (int i = 0; i < 16; i++) begin
            eng_ena_1  = 1'b1;
            eng_ena_2  = 1'b1;
            eng_wea_2  = 1'b0;
            eng_addr_1 = ADDR_W'(i);
            eng_addr_2 = ADDR_W'(i);
            @(posedge clk);
            #1;
            a = int'(eng_dout_1);
            b = int'(eng_dout_2);
            checkOutput("eng_rd_a", eng_dout_1, i);
            checkOutput("eng_rd_b", eng_dout_2, 16 + i);
            eng_ena_1 = 1'b0;
            eng_wea_2 = 1'b1;
            eng_din_2 = DATA_W'((a + b) / 2);
            @(posedge clk);
            #1;
            eng_ena_2 = 1'b0;
            eng_wea_2 = 1'b0;
        end

        // Write-first: the written byte shows up on dout the very next cycle
        eng_ena_2  = 1'b1;
        eng_wea_2  = 1'b1;
        eng_addr_2 = 4'd3;
        eng_din_2  = 8'hAA;
        @(posedge clk);
        #1;
        checkOutput("write_first_aa", eng_dout_2, 8'hAA);
        eng_din_2 = 8'd11;
        @(posedge clk);
        #1;
        checkOutput("write_first_11", eng_dout_2, 11);
        eng_ena_2 = 1'b0;
        eng_wea_2 = 1'b0;

        m_ready     = 1'b1;
        engine_done = 1'b1;
        @(posedge clk);
        #1;
        engine_done = 1'b0;
        checkOutput("dump1_begin_engine", begin_engine, 0);

        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            checkOutput("dump1_m_valid", m_valid, (k >= 2));
            if (k >= 2) checkOutput("dump1_m_data", m_data, 8 + k - 2);
            if (k == 5) checkOutput("dump1_eng_dout_hold", eng_dout_2, 11);
            checkOutput("dump1_done_low", done, 0);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        checkOutput("fin1_done", done, 1);
        checkOutput("fin1_busy", busy, 1);
        checkOutput("fin1_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("after_fin1_done", done, 0);
        checkOutput("after_fin1_busy", busy, 0);
        repeat (3) @(negedge clk);
        checkOutput("fin_start_ignored", busy, 0);

        // Run 2: engine ports poked outside RUN, start pulsed mid-load,
        // engine leaves banks alone, dump with m_ready 1,0,0,1
        @(posedge clk);
        #1;
        eng_ena_1 = 1'b1; eng_wea_1 = 1'b1; eng_addr_1 = 4'd2; eng_din_1 = 8'hEE;
        eng_ena_2 = 1'b1; eng_wea_2 = 1'b1; eng_addr_2 = 4'd2; eng_din_2 = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        pulseStart();
        applyStimulus(0, 32, 1, 1);
        eng_ena_1 = 1'b0; eng_wea_1 = 1'b0; eng_ena_2 = 1'b0; eng_wea_2 = 1'b0;
        checkOutput("run2_begin_engine", begin_engine, 1);
        pulseStart();
        checkOutput("run2_start_ignored", begin_engine, 1);
        engine_done = 1'b1;
        @(posedge clk);
        #1;
        engine_done = 1'b0;

        idx   = 0;
        c     = 0;
        stall = 1'b0;
        while (idx < 16 && c < 200) begin
            m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            @(negedge clk);
            if (stall) checkOutput("dump2_hold_valid", m_valid, 1);
            if (m_valid) begin
                checkOutput("dump2_m_data", m_data, 16 + idx);
                if (m_ready) idx++;
            end
            stall = m_valid && !m_ready;
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("dump2_count", idx, 16);
        @(negedge clk);
        checkOutput("fin2_done", done, 1);
        checkOutput("fin2_m_valid", m_valid, 0);
        @(negedge clk);
        checkOutput("after_fin2_done", done, 0);
        checkOutput("after_fin2_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/im_bram_host.md
Name: im_bram_host

Overview:
- Host-side responder for the image-engine BRAM port bundle; it is the memory-and-sequencing end of the interface that pixel engines (e.g. the image adder) drive.
- Owns two N*N x 8 image banks and loads them from a byte stream, then hands both banks to an engine via begin/done.
- After the engine finishes, streams bank 2 back out.
- Sits between the UART/host byte path and any engine exposing ena/wea/addr/din/dout pairs.

Parameters:
- N, 128, image side in pixels; bank depth is N*N.
- ADDR_W, 14, bank address width; must satisfy 2**ADDR_W >= N*N.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a load/run/dump sequence
- busy  out  1  high from accepted start until done pulse
- done  out  1  one-cycle pulse after last output byte accepted
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid&&s_ready
- s_data  in  DATA_W  input pixel, raster order
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accepts when m_valid&&m_ready
- m_data  out  DATA_W  output pixel, raster order
- begin_engine  out  1  engine run enable (level)
- engine_done  in  1  engine completion (level)
- eng_ena_1, eng_ena_2  in  1  engine bank enables
- eng_wea_1, eng_wea_2  in  1  engine bank write enables
- eng_addr_1, eng_addr_2  in  ADDR_W  engine bank addresses
- eng_din_1, eng_din_2  in  DATA_W  engine write data
- eng_dout_1, eng_dout_2  out  DATA_W  bank read data to engine

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, s_ready=0, m_valid=0, m_data=0, begin_engine=0, eng_dout_*=0, counters=0. Bank contents are not cleared.
- Banks: single port; a read is registered with 1-cycle latency while ena=1. Write-first: on a write cycle, dout <= din. When ena=0, dout holds its value.
- States: IDLE -> LOAD_A -> LOAD_B -> RUN -> DUMP -> FIN -> IDLE.
- IDLE: start=1 moves to LOAD_A and sets busy=1 from the next cycle. start in any other state is ignored.
- LOAD_A / LOAD_B:
  - s_ready=1.
  - Each handshake writes s_data to bank 1 (LOAD_A) or bank 2 (LOAD_B) at cnt, then increments cnt.
  - At cnt==N*N-1 with a handshake: cnt<=0 and advance to the next state.
  - Stalls on s_valid=0 indefinitely; there is no timeout.
- RUN:
  - begin_engine=1. Engine ports are muxed onto both banks; eng_dout_* follow bank dout.
  - Outside RUN, engine ena/wea are forced to 0 internally and eng_dout_* hold.
  - engine_done=1 sampled in RUN: begin_engine<=0 and go to DUMP.
  - engine_done is ignored outside RUN. Engines must clear done when begin_engine falls.
- DUMP:
  - Reads bank 2 addresses 0..N*N-1 in order into a 2-entry output skid buffer.
  - First m_valid is 2 cycles after DUMP entry. With m_ready held high, throughput is 1 byte/cycle.
  - m_data/m_valid stay stable while m_valid&&!m_ready; no byte is dropped or duplicated.
  - Read address advances only when the skid buffer has space.
- FIN: entered on acceptance of byte N*N-1. done=1 for exactly one cycle, busy<=0, return to IDLE.
- Address wrap: counters never exceed N*N-1. For N*N < 2**ADDR_W, upper addresses are never touched by the host.
- Simultaneous events:
  - start coincident with FIN is ignored; it is accepted only in IDLE.
  - s_valid outside LOAD states is held off (s_ready=0).
- Reset mid-operation drops the stream position. The next start reloads from address 0.

Decomposition:
- Package im_pkg: N, ADDR_W, DATA_W defaults; state encoding (IDLE, LOAD_A, LOAD_B, RUN, DUMP, FIN).
- Sub-module im_bram_bank: inferred single-port RAM, write-first, registered read. Instantiated twice, with port mux in the parent.

Test Plan:
- N=4. rst pulse mid-LOAD_B after 5 bytes -> all outputs 0, state IDLE. New start, 32 bytes in -> s_ready drops after byte 32, begin_engine=1.
- N=4. Load A=0..15, B=16..31. Stub engine writes eng_din_2=(A+B)/2 (8..23) then raises engine_done -> m_data sequence 8,9,...,23. done pulses 1 cycle after the 16th accept.
- DUMP with m_ready toggling 1,0,0,1 repeating -> 16 bytes each emitted exactly once in order. m_data stable during stalls.
- DUMP with m_ready=1 constant -> first m_valid 2 cycles after DUMP entry, then 16 consecutive valid cycles.
- start asserted during LOAD_A, RUN and FIN -> no effect. Engine ena/wea driven in IDLE -> bank contents unchanged (verified by later dump).
- Engine writes bank 2 address 3 with 0xAA and reads it back the next cycle -> eng_dout_2=0xAA on the write cycle+1 (write-first).
